l2_port_arbiter: RTL
====================

Name: l2_port_arbiter

Overview:
- Shares one L2 memory port between three requesters: the instruction-cache read port, the data-cache read port and the data-cache write port.
- Serialises whole burst transactions, one outstanding at a time.
- Arbitration order: the write port has fixed top priority; the two read ports are round-robin.
- Sits between the RISCV_PROCESSOR L2 buses and the L2 cache / memory emulator.

Parameters:
- W, 7, L2 bus width is 2^W bits (BUS = 1<<W).
- B, 9, cache block size is 2^B bits; L2_BURST = 1<<(B-W) beats per transaction.
- ADDR_WIDTH, 32, byte address width; word addresses are ADDR_WIDTH-2 bits (AW).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- INS_ADDR / INS_ADDR_VALID / INS_ADDR_READY  in/in/out  AW/1/1  instruction read request.
- INS_DATA / INS_DATA_VALID / INS_DATA_READY  out/out/in  BUS/1/1  instruction read data.
- DAT_RD_ADDR / DAT_RD_ADDR_VALID / DAT_RD_ADDR_READY  in/in/out  AW/1/1  data read request.
- DAT_DATA / DAT_DATA_VALID / DAT_DATA_READY  out/out/in  BUS/1/1  data read data.
- DAT_WR_ADDR / DAT_WR_DATA / DAT_WR_VALID / DAT_WR_READY  in/in/in/out  AW/BUS/1/1  data write burst; the address is valid with the first beat.
- DAT_WR_COMPLETE  out  1  write-done pulse.
- MEM_ADDR / MEM_WE / MEM_REQ_VALID / MEM_REQ_READY  out/out/out/in  AW/1/1/1  memory request channel.
- MEM_WR_DATA / MEM_WR_VALID / MEM_WR_READY  out/out/in  BUS/1/1  memory write data.
- MEM_WR_COMPLETE  in  1  memory write acknowledge.
- MEM_RD_DATA / MEM_RD_VALID / MEM_RD_READY  in/in/out  BUS/1/1  memory read data.

Behaviour:
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_WAIT.
- Reset (async, RSTN=0):
  - State goes to IDLE; beat counter = 0; MEM_ADDR = 0; MEM_WE = 0.
  - last_grant = DAT, so INS wins the first read tie.
  - All VALID, READY and COMPLETE outputs are 0.
  - A reset in the middle of a burst abandons the transaction; no partial state survives.
- IDLE arbitration (combinational):
  - DAT_WR_VALID wins over any read.
  - If both read VALIDs are high, grant the port that is not last_grant.
  - Otherwise grant whichever read port is valid.
- IDLE, read winner:
  - Only the winner's ADDR_READY = 1 that cycle.
  - Latch the address, grant and MEM_WE=0; set last_grant; go to RD_REQ.
- IDLE, write winner:
  - Latch DAT_WR_ADDR and MEM_WE=1; go to WR_REQ.
  - DAT_WR_READY stays 0 in IDLE and WR_REQ; no beat is consumed yet.
- RD_REQ / WR_REQ:
  - MEM_REQ_VALID = 1 with the latched MEM_ADDR/MEM_WE, held stable until MEM_REQ_READY.
  - On handshake go to RD_DATA / WR_DATA.
  - Latency from address accept to MEM_REQ_VALID is 1 cycle.
- RD_DATA:
  - Granted DATA and VALID = MEM_RD_DATA and MEM_RD_VALID, combinational pass-through; the other port's VALID = 0.
  - MEM_RD_READY = granted port's DATA_READY.
  - Count beats where VALID && READY. After beat L2_BURST-1 is accepted, clear the counter and go to IDLE.
  - New arbitration is possible on the next cycle.
- WR_DATA:
  - MEM_WR_VALID = DAT_WR_VALID; MEM_WR_DATA = DAT_WR_DATA; DAT_WR_READY = MEM_WR_READY.
  - Count beats; after L2_BURST accepted beats go to WR_WAIT.
- WR_WAIT:
  - DAT_WR_COMPLETE = MEM_WR_COMPLETE (combinational, 1 cycle); on MEM_WR_COMPLETE go to IDLE.
  - A MEM_WR_COMPLETE seen in any other state is ignored.
- Requests arriving while not in IDLE see ADDR_READY = 0 and must hold VALID.
- Beat counter width is B-W bits. Compare against L2_BURST-1, with no wrap into a new burst; when B = W the burst is a single beat.
- Round-robin pointer updates only on read grants. Writes do not change last_grant.

Test Plan:
- Reset with all inputs idle -> all outputs 0. Deassert RSTN, INS_ADDR_VALID with addr 0x100 -> INS_ADDR_READY same cycle; MEM_REQ_VALID, MEM_ADDR=0x100, MEM_WE=0 next cycle.
- INS and DAT read valid in the same cycle, twice in a row -> INS granted first, DAT second. 4 beats (L2_BURST=4) each routed only to the granted port.
- DAT_WR_VALID and both reads valid together -> write granted; 4 beats forwarded. MEM_WR_COMPLETE after 4 cycles -> DAT_WR_COMPLETE pulse; INS read granted next.
- Read burst with DAT_DATA_READY dropped for 3 cycles mid-burst -> MEM_RD_READY follows it; exactly 4 beats counted; return to IDLE after the 4th.
- MEM_REQ_READY held low for 5 cycles -> MEM_REQ_VALID and MEM_ADDR stable; no other port is granted.
- RSTN asserted during beat 2 of a write -> immediate IDLE, outputs 0. Next read proceeds normally with counter 0.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Shares one L2 memory port between the I-cache read, D-cache read and D-cache write ports.
// Whole bursts are serialised; writes have fixed priority, the two read ports alternate.
module l2_port_arbiter #(
  parameter int W          = 7,
  parameter int B          = 9,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [ADDR_WIDTH-3:0]   INS_ADDR,
  input  logic                    INS_ADDR_VALID,
  output logic                    INS_ADDR_READY,
  output logic [(1<<W)-1:0]       INS_DATA,
  output logic                    INS_DATA_VALID,
  input  logic                    INS_DATA_READY,
  input  logic [ADDR_WIDTH-3:0]   DAT_RD_ADDR,
  input  logic                    DAT_RD_ADDR_VALID,
  output logic                    DAT_RD_ADDR_READY,
  output logic [(1<<W)-1:0]       DAT_DATA,
  output logic                    DAT_DATA_VALID,
  input  logic                    DAT_DATA_READY,
  input  logic [ADDR_WIDTH-3:0]   DAT_WR_ADDR,
  input  logic [(1<<W)-1:0]       DAT_WR_DATA,
  input  logic                    DAT_WR_VALID,
  output logic                    DAT_WR_READY,
  output logic                    DAT_WR_COMPLETE,
  output logic [ADDR_WIDTH-3:0]   MEM_ADDR,
  output logic                    MEM_WE,
  output logic                    MEM_REQ_VALID,
  input  logic                    MEM_REQ_READY,
  output logic [(1<<W)-1:0]       MEM_WR_DATA,
  output logic                    MEM_WR_VALID,
  input  logic                    MEM_WR_READY,
  input  logic                    MEM_WR_COMPLETE,
  input  logic [(1<<W)-1:0]       MEM_RD_DATA,
  input  logic                    MEM_RD_VALID,
  output logic                    MEM_RD_READY
);

  localparam int L2_BURST = 1 << (B - W);
  localparam int CW       = (B > W) ? (B - W) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(L2_BURST - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] WR_WAIT = 3'd5;

  localparam logic GNT_INS = 1'b0;
  localparam logic GNT_DAT = 1'b1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          grant;
  logic          last_grant;
  logic          rd_pick;
  logic          rd_any;
  logic          idle;
  logic          rd_beat;
  logic          wr_beat;

  // Read round-robin: on a tie the port that did not win last time is chosen.
  always_comb begin
    rd_pick = GNT_INS;
    if (INS_ADDR_VALID && DAT_RD_ADDR_VALID)
      rd_pick = ~last_grant;
    else if (DAT_RD_ADDR_VALID)
      rd_pick = GNT_DAT;
  end

  assign rd_any = INS_ADDR_VALID || DAT_RD_ADDR_VALID;
  assign idle   = (state == IDLE);

  assign INS_ADDR_READY    = idle && !DAT_WR_VALID && INS_ADDR_VALID    && (rd_pick == GNT_INS);
  assign DAT_RD_ADDR_READY = idle && !DAT_WR_VALID && DAT_RD_ADDR_VALID && (rd_pick == GNT_DAT);

  assign MEM_REQ_VALID = (state == RD_REQ) || (state == WR_REQ);

  assign INS_DATA       = MEM_RD_DATA;
  assign DAT_DATA       = MEM_RD_DATA;
  assign INS_DATA_VALID = (state == RD_DATA) && (grant == GNT_INS) && MEM_RD_VALID;
  assign DAT_DATA_VALID = (state == RD_DATA) && (grant == GNT_DAT) && MEM_RD_VALID;
  assign MEM_RD_READY   = (state == RD_DATA) &&
                          ((grant == GNT_DAT) ? DAT_DATA_READY : INS_DATA_READY);

  assign MEM_WR_DATA     = DAT_WR_DATA;
  assign MEM_WR_VALID    = (state == WR_DATA) && DAT_WR_VALID;
  assign DAT_WR_READY    = (state == WR_DATA) && MEM_WR_READY;
  assign DAT_WR_COMPLETE = (state == WR_WAIT) && MEM_WR_COMPLETE;

  assign rd_beat = MEM_RD_VALID && MEM_RD_READY;
  assign wr_beat = MEM_WR_VALID && MEM_WR_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= GNT_INS;
      last_grant <= GNT_DAT;
      MEM_ADDR   <= '0;
      MEM_WE     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DAT_WR_VALID) begin
            MEM_ADDR <= DAT_WR_ADDR;
            MEM_WE   <= 1'b1;
            state    <= WR_REQ;
          end else if (rd_any) begin
            MEM_ADDR   <= (rd_pick == GNT_DAT) ? DAT_RD_ADDR : INS_ADDR;
            MEM_WE     <= 1'b0;
            grant      <= rd_pick;
            last_grant <= rd_pick;
            state      <= RD_REQ;
          end
        end
        RD_REQ:  if (MEM_REQ_READY) state <= RD_DATA;
        WR_REQ:  if (MEM_REQ_READY) state <= WR_DATA;
        RD_DATA: begin
          if (rd_beat) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WR_DATA: begin
          if (wr_beat) begin
            if (cnt == LAST_BEAT) begin
              cnt   <= '0;
              state <= WR_WAIT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WR_WAIT: if (MEM_WR_COMPLETE) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
